// File: rtl/snd_axi_rdma.sv
// AXI4 burst-read DMA that streams a PCM buffer from DRAM into the sound sample FIFO.
// Supports several bursts in flight, FIFO space reservation, pause/resume, stop-with-discard and looping.
module snd_axi_rdma #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int FIFO_DEPTH      = 2048,
  parameter int CNT_WIDTH       = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            COMMAND,
  input  logic                  LOOP,
  input  logic [ADDR_WIDTH-1:0] SNDADDR,
  input  logic [ADDR_WIDTH-1:0] SNDSIZE,
  input  logic [CNT_WIDTH-1:0]  FIFO_WRCNT,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  input  logic                  RLAST,
  input  logic [1:0]            RRESP,
  output logic                  RREADY,
  output logic                  FIFO_WREN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [2:0]            DBG_STATE
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] BB      = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BB_MASK = ~(BB - ADDR_WIDTH'(1));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] size_q, size_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic rready, ar_hs, r_hs, last_hs, stop, end_of_buf, room;

  assign rready = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    offset_d   = offset_q;
    araddr_d   = araddr_q;
    out_d      = out_q;
    arvalid_d  = arvalid_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ar_hs      = arvalid_q & ARREADY;
    r_hs       = RVALID & rready;
    last_hs    = r_hs & RLAST;
    stop       = (COMMAND == 2'b00) || (COMMAND == 2'b11);
    end_of_buf = 1'b0;
    // Reserve FIFO space for every burst already in flight plus the one about to be issued.
    room = (32'(FIFO_WRCNT) + (32'(out_q) + 32'd1) * 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);

    if (ar_hs) begin
      arvalid_d = 1'b0;
      if (offset_q + BB >= size_q) begin
        offset_d   = LOOP ? '0 : offset_q + BB;
        end_of_buf = !LOOP;
      end else begin
        offset_d = offset_q + BB;
      end
    end

    case ({ar_hs, last_hs})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    if (r_hs && RRESP != 2'b00) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (COMMAND == 2'b01) begin
          base_d   = SNDADDR;
          size_d   = SNDSIZE & BB_MASK;
          offset_d = '0;
          err_d    = 1'b0;
          state_d  = ((SNDSIZE & BB_MASK) == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_ABORT;
        end else if (end_of_buf) begin
          state_d = S_DRAIN;
        end else if (COMMAND == 2'b10) begin
          state_d = S_PAUSE;
        end else if (!arvalid_q && out_q < OW'(MAX_OUTSTANDING) && room) begin
          arvalid_d = 1'b1;
          araddr_d  = base_q + offset_q;
        end
      end
      S_PAUSE: begin
        if (stop)                    state_d = S_ABORT;
        else if (end_of_buf)         state_d = S_DRAIN;
        else if (COMMAND == 2'b01)   state_d = S_RUN;
      end
      S_DRAIN: begin
        if (stop) begin
          state_d = S_ABORT;
        end else if (out_q == '0 && !arvalid_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        // A pending AR must still complete; its data is sunk without FIFO writes.
        if (out_q == '0 && !arvalid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      size_q    <= '0;
      offset_q  <= '0;
      araddr_q  <= '0;
      out_q     <= '0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      size_q    <= size_d;
      offset_q  <= offset_d;
      araddr_q  <= araddr_d;
      out_q     <= out_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ARADDR    = araddr_q;
  assign ARLEN     = 8'(BURST_LEN - 1);
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready;
  assign FIFO_WREN = r_hs & (state_q != S_ABORT);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_snd_axi_rdma.sv
// Bench for snd_axi_rdma: AXI read slave model, AR address scoreboard, table of play cases
// and hand-written sequences for loop, FIFO reservation, abort, pause/error and reset.
module tb_snd_axi_rdma;

  localparam int BL = 32;
  localparam int DW = 64;
  localparam logic [31:0] BB = 32'(BL * DW / 8);

  logic        ACLK;
  logic        ARESETN;
  logic [1:0]  COMMAND;
  logic        LOOP;
  logic [31:0] SNDADDR, SNDSIZE;
  logic [11:0] FIFO_WRCNT;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [1:0]  RRESP;
  logic        FIFO_WREN, BUSY, DONE, ERR;
  logic [2:0]  DBG_STATE;

  snd_axi_rdma dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .COMMAND(COMMAND), .LOOP(LOOP),
    .SNDADDR(SNDADDR), .SNDSIZE(SNDSIZE), .FIFO_WRCNT(FIFO_WRCNT),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY),
    .FIFO_WREN(FIFO_WREN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  bit ar_hold = 1'b0;
  bit r_en = 1'b1;
  bit inject_err = 1'b0;
  int pend = 0, beat = 0, out_m = 0, max_out = 0;
  int ar_cnt = 0, wren_cnt = 0, done_cnt = 0;

  typedef struct {
    bit          lp;
    logic [31:0] addr;
    logic [31:0] size;
    logic [11:0] wrcnt;
    int          n_ar;
    int          n_wren;
    int          max_o;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr_counters();
    ar_cnt = 0; wren_cnt = 0; done_cnt = 0; max_out = 0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    while (cyc < budget && !seen) begin
      @(negedge ACLK);
      cyc++;
      if (DONE) begin
        seen = 1'b1;
        COMMAND = 2'b00;
      end
    end
    COMMAND = 2'b00;
  endtask

  task automatic push_addrs(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(k) * BB);
  endtask

  // AXI read slave: accepts ARs, returns BL-beat bursts with random gaps, counts FIFO writes
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        pend = 0; beat = 0; out_m = 0;
        continue;
      end
      if (DONE) done_cnt++;
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      if (pend > 0 && r_en && $urandom_range(0, 3) != 0) begin
        RVALID = 1'b1;
        RLAST  = (beat == BL - 1);
        if (inject_err) begin
          RRESP = 2'b10;
          inject_err = 1'b0;
        end
        if (RREADY) begin
          if (beat == BL - 1) begin
            beat = 0; pend--; out_m--;
          end else begin
            beat++;
          end
        end
      end
      ARREADY = !ar_hold;
      if (ARVALID && ARREADY) begin
        ar_cnt++; pend++; out_m++;
        if (out_m > max_out) max_out = out_m;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ar: got 0x%0h expected no AR", ARADDR);
        end else begin
          chk("araddr", {32'b0, ARADDR}, {32'b0, exp_q.pop_front()});
        end
      end
      #1;
      if (FIFO_WREN) wren_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  stable_bad;
    bit  seen;
    logic [31:0] es;

    vecs[0] = '{1'b0, 32'h2000_0000, 32'h0000_0800, 12'd0,    8, 256, 2,  -1};
    vecs[1] = '{1'b0, 32'h0000_1000, 32'h0000_03FF, 12'd0,    3,  96, 2,  -1};
    vecs[2] = '{1'b0, 32'h1234_0000, 32'h0000_00FF, 12'd0,    0,   0, 0,   2};
    vecs[3] = '{1'b0, 32'hFFFF_FF00, 32'h0000_0200, 12'd0,    2,  64, 2,  -1};
    vecs[4] = '{1'b0, 32'h0800_0000, 32'h0000_0400, 12'd1990, 4, 128, 1,  -1};

    ARESETN = 1'b0; COMMAND = 2'b00; LOOP = 1'b0;
    SNDADDR = '0; SNDSIZE = '0; FIFO_WRCNT = '0;
    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_araddr", ARADDR, 32'h0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_wren", FIFO_WREN, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("arlen", ARLEN, 8'd31);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // table-driven play cases
    for (int i = 0; i < 5; i++) begin
      es = vecs[i].size & ~(BB - 32'd1);
      push_addrs(vecs[i].addr, int'(es / BB));
      clr_counters();
      LOOP = vecs[i].lp; SNDADDR = vecs[i].addr; SNDSIZE = vecs[i].size;
      FIFO_WRCNT = vecs[i].wrcnt;
      COMMAND = 2'b01;
      wait_done(4000, cyc, seen);
      chk($sformatf("v%0d_done_seen", i), seen, 1'b1);
      if (vecs[i].lat >= 0) chk($sformatf("v%0d_done_lat", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_busy_at_done", i), BUSY, 1'b0);
      chk($sformatf("v%0d_ar_cnt", i), ar_cnt, vecs[i].n_ar);
      chk($sformatf("v%0d_wren_cnt", i), wren_cnt, vecs[i].n_wren);
      chk($sformatf("v%0d_max_out", i), max_out, vecs[i].max_o);
      chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
      @(negedge ACLK);
      chk($sformatf("v%0d_done_pulse", i), DONE, 1'b0);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      exp_q.delete();
      FIFO_WRCNT = '0;
      repeat (2) @(negedge ACLK);
    end

    // loop, then clear LOOP mid-pass
    clr_counters();
    push_addrs(32'h0500_0000, 3); push_addrs(32'h0500_0000, 3);
    LOOP = 1'b1; SNDADDR = 32'h0500_0000; SNDSIZE = 32'h300; COMMAND = 2'b01;
    cyc = 0;
    while (ar_cnt < 4 && cyc < 2000) begin @(negedge ACLK); cyc++; end
    LOOP = 1'b0;
    wait_done(3000, cyc, seen);
    chk("loop_done_seen", seen, 1'b1);
    chk("loop_ar_cnt", ar_cnt, 6);
    chk("loop_wren_cnt", wren_cnt, 192);
    chk("loop_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge ACLK);

    // FIFO nearly full: no burst fits
    clr_counters();
    FIFO_WRCNT = 12'd2017; SNDADDR = 32'h0600_0000; SNDSIZE = 32'h800; COMMAND = 2'b01;
    repeat (40) @(negedge ACLK);
    chk("full_no_ar", ar_cnt, 0);
    chk("full_arvalid", ARVALID, 1'b0);
    chk("full_busy", BUSY, 1'b1);
    COMMAND = 2'b00;
    repeat (3) @(negedge ACLK);
    chk("full_stop_idle", BUSY, 1'b0);
    chk("full_no_done", done_cnt, 0);
    FIFO_WRCNT = '0;

    // stop while AR stalled: AR held, data discarded
    clr_counters();
    ar_hold = 1'b1;
    exp_q.push_back(32'h4000_0000);
    SNDADDR = 32'h4000_0000; SNDSIZE = 32'h800; COMMAND = 2'b01;
    cyc = 0;
    while (!ARVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
    chk("abort_arvalid_seen", ARVALID, 1'b1);
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      if (c == 2) COMMAND = 2'b00;
      if (!(ARVALID === 1'b1 && ARADDR === 32'h4000_0000)) stable_bad++;
    end
    chk("abort_ar_stable", stable_bad, 0);
    chk("abort_state", DBG_STATE, 3'd4);
    ar_hold = 1'b0;
    cyc = 0;
    while (BUSY && cyc < 500) begin @(negedge ACLK); cyc++; end
    chk("abort_idle", BUSY, 1'b0);
    chk("abort_ar_cnt", ar_cnt, 1);
    chk("abort_no_wren", wren_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge ACLK);

    // pause after two bursts, error beat, resume
    clr_counters();
    push_addrs(32'h3000_0000, 8);
    inject_err = 1'b1;
    SNDADDR = 32'h3000_0000; SNDSIZE = 32'h800; COMMAND = 2'b01;
    cyc = 0;
    while (ar_cnt < 2 && cyc < 200) begin @(negedge ACLK); cyc++; end
    COMMAND = 2'b10;
    repeat (200) @(negedge ACLK);
    chk("pause_no_ar", ar_cnt, 2);
    chk("pause_inflight_wren", wren_cnt, 64);
    chk("pause_state", DBG_STATE, 3'd2);
    chk("pause_err", ERR, 1'b1);
    COMMAND = 2'b01;
    wait_done(4000, cyc, seen);
    chk("resume_done_seen", seen, 1'b1);
    chk("resume_ar_cnt", ar_cnt, 8);
    chk("resume_wren_cnt", wren_cnt, 256);
    chk("resume_sb_empty", exp_q.size(), 0);
    repeat (5) @(negedge ACLK);
    chk("err_sticky_idle", ERR, 1'b1);
    exp_q.delete();

    // restart clears ERR; then reset mid-burst
    clr_counters();
    push_addrs(32'h7000_0000, 8);
    SNDADDR = 32'h7000_0000; SNDSIZE = 32'h800; COMMAND = 2'b01;
    repeat (2) @(negedge ACLK);
    chk("err_cleared_on_start", ERR, 1'b0);
    cyc = 0;
    while ((ar_cnt < 2 || wren_cnt < 5) && cyc < 500) begin @(negedge ACLK); cyc++; end
    chk("midburst_busy", BUSY, 1'b1);
    ARESETN = 1'b0;
    #1;
    chk("mrst_arvalid", ARVALID, 1'b0);
    chk("mrst_araddr", ARADDR, 32'h0);
    chk("mrst_rready", RREADY, 1'b0);
    chk("mrst_wren", FIFO_WREN, 1'b0);
    chk("mrst_busy", BUSY, 1'b0);
    chk("mrst_done", DONE, 1'b0);
    chk("mrst_err", ERR, 1'b0);
    chk("mrst_state", DBG_STATE, 3'd0);
    COMMAND = 2'b00;
    repeat (2) @(negedge ACLK);
    exp_q.delete();
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("post_rst_idle", BUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
